// File: rtl/mp_io_pkg.sv
// Shared constants for the mp_io_port byte I/O peripheral.
package mp_io_pkg;
  localparam int                DATA_W        = 8;
  localparam logic [DATA_W-1:0] IDLE_BYTE     = 8'h00;
  localparam int                IN_DEPTH_DEF  = 4;
  localparam int                OUT_DEPTH_DEF = 4;
endpackage

// File: rtl/mp_io_fifo.sv
// First-word-fall-through byte FIFO; the head is visible whenever not empty,
// and an empty FIFO presents IDLE_BYTE. A pop on a full FIFO frees a slot for a same-cycle push.
module mp_io_fifo
  import mp_io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         push_data_i,
  input  logic                      pop_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = empty_o ? IDLE_BYTE : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes it.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/mp_io_port.sv
// Byte I/O port between a host valid/ready interface and the CPU IN/OUT buses.
// Optional MP_IO_CHANGE_DETECT_EN: capture the CPU OUT bus on value change instead of cpu_wr.
module mp_io_port
  import mp_io_pkg::*;
#(
  parameter int IN_DEPTH  = IN_DEPTH_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [DATA_W-1:0] cpu_in,
  output logic              cpu_in_avail,
  input  logic              cpu_rd,
  input  logic [DATA_W-1:0] cpu_out,
  input  logic              cpu_wr,
  output logic [DATA_W-1:0] host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic              out_overflow,
  output logic              rd_underflow
);
  logic                      in_full, in_empty;
  logic                      out_full, out_empty;
  logic [$clog2(IN_DEPTH):0]  in_count;
  logic [$clog2(OUT_DEPTH):0] out_count;
  logic                      in_push, out_pop;
  logic                      out_push_req;
  logic [DATA_W-1:0]         out_push_data;
  logic                      ovf_q, ovf_d;
  logic                      unf_q, unf_d;
  logic                      unused_counts;

  assign host_in_ready  = !in_full;
  assign in_push        = host_in_valid && !in_full;
  assign cpu_in_avail   = !in_empty;
  assign host_out_valid = !out_empty;
  assign out_pop        = !out_empty && host_out_ready;
  assign unused_counts  = ^{in_count, out_count};

  mp_io_fifo #(.DEPTH(IN_DEPTH)) u_in_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (in_push),
    .push_data_i (host_in_data),
    .pop_i       (cpu_rd),
    .data_o      (cpu_in),
    .full_o      (in_full),
    .empty_o     (in_empty),
    .count_o     (in_count)
  );

  mp_io_fifo #(.DEPTH(OUT_DEPTH)) u_out_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (out_push_req),
    .push_data_i (out_push_data),
    .pop_i       (out_pop),
    .data_o      (host_out_data),
    .full_o      (out_full),
    .empty_o     (out_empty),
    .count_o     (out_count)
  );

`ifdef MP_IO_CHANGE_DETECT_EN
  logic [DATA_W-1:0] cpu_out_q;
  logic [DATA_W-1:0] last_out_q, last_out_d;
  logic              unused_cpu_wr;

  assign unused_cpu_wr = cpu_wr;
  assign out_push_req  = (cpu_out_q != last_out_q);
  assign out_push_data = cpu_out_q;
  // last_out follows every change event, even when the byte is dropped.
  assign last_out_d    = out_push_req ? cpu_out_q : last_out_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_out_q  <= IDLE_BYTE;
      last_out_q <= IDLE_BYTE;
    end else begin
      cpu_out_q  <= cpu_out;
      last_out_q <= last_out_d;
    end
  end
`else
  assign out_push_req  = cpu_wr;
  assign out_push_data = cpu_out;
`endif

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (out_push_req && out_full && !out_pop) ovf_d = 1'b1;
    if (cpu_rd && in_empty)                   unf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign out_overflow = ovf_q;
  assign rd_underflow = unf_q;
endmodule
